// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM encoding and per-transfer mode.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, BPORCH, DONE} state_t;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;
endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: free-runs 0..SCLK_DIV-1 while enabled, held at 0 otherwise.
module spi_clk_gen #(
  parameter int SCLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk_ph,
  output logic lead_edge,
  output logic trail_edge
);
  localparam int HALF = SCLK_DIV / 2;
  localparam int CW   = $clog2(SCLK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst)                   cnt <= '0;
    else if (!en || trail_edge) cnt <= '0;
    else                       cnt <= cnt + 1'b1;

  // Strobes mark the clk edge on which SCLK changes level.
  assign lead_edge  = en && (cnt == CW'(HALF - 1));
  assign trail_edge = en && (cnt == CW'(SCLK_DIV - 1));
  assign sclk_ph    = en && (cnt >= CW'(HALF));
endmodule

// File: rtl/spi_master_cfg.sv
// Parametrised full-duplex SPI master with per-transfer CPOL/CPHA and one-hot slave selects.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SCLK_DIV  = 32,
  parameter int NUM_SS    = 4,
  parameter int BP_CYCLES = 8,
  localparam int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] SPI_data_out
);
  localparam int HALF = SCLK_DIV / 2;
  localparam int TMAX = (HALF > BP_CYCLES) ? HALF : BP_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DATA_W);

  state_t            state, state_nxt;
  spi_mode_t         mode;
  logic [TW-1:0]     tmr;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [SS_W-1:0]   sel;
  logic [1:0]        miso_sync;
  logic              sclk_ph, lead_edge, trail_edge;
  logic              active, last_bit, smp, shf;

  spi_clk_gen #(.SCLK_DIV(SCLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (state == XFER),
    .sclk_ph   (sclk_ph),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge)
  );

  assign last_bit = (bit_cnt == BW'(DATA_W - 1));

  always_comb begin
    state_nxt = state;
    active    = (state == SETUP) || (state == XFER) || (state == BPORCH);
    busy      = active;
    done      = (state == DONE);
    SCLK      = mode.cpol ^ sclk_ph;
    MOSI      = active & tx_sr[DATA_W-1];
    // cpha=1 holds the MSB through the first leading edge; cpha=0 keeps the LSB after the last sample.
    smp = (state == XFER) && (mode.cpha ? trail_edge : lead_edge);
    shf = (state == XFER) && (mode.cpha ? (lead_edge && bit_cnt != '0)
                                        : (trail_edge && !last_bit));
    for (int i = 0; i < NUM_SS; i++)
      SS_n[i] = !(active && sel == SS_W'(i));
    case (state)
      IDLE:    if (wrt) state_nxt = SETUP;
      SETUP:   if (tmr == TW'(HALF - 1)) state_nxt = XFER;
      XFER:    if (trail_edge && last_bit) state_nxt = BPORCH;
      BPORCH:  if (tmr == TW'(BP_CYCLES - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      mode         <= '0;
      tmr          <= '0;
      bit_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      sel          <= '0;
      miso_sync    <= '0;
      SPI_data_out <= '0;
    end else begin
      state     <= state_nxt;
      miso_sync <= {miso_sync[0], MISO};
      // One timer serves both SETUP and BPORCH; it restarts on every state change.
      tmr <= (state_nxt == state && (state == SETUP || state == BPORCH)) ? tmr + 1'b1 : '0;
      if (state == IDLE && wrt) begin
        tx_sr   <= cmd;
        sel     <= ss_sel;
        mode    <= '{cpol: cpol, cpha: cpha};
        bit_cnt <= '0;
      end
      if (shf) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      if (smp) rx_sr <= {rx_sr[DATA_W-2:0], miso_sync[1]};
      if (state == XFER && trail_edge && !last_bit) bit_cnt <= bit_cnt + 1'b1;
      if (state == DONE) SPI_data_out <= rx_sr;
    end
endmodule
